// File: rtl/frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the erase/update/draw engines.
// The scheduler takes the master view; the frame source and engines take the slave view.
interface frame_scheduler_if;
    logic       tick;
    logic       enable;
    logic       done_erase;
    logic       done_update;
    logic       done_draw;
    logic       start_erase;
    logic       start_update;
    logic       start_draw;
    logic       busy;
    logic       overrun;
    logic       timeout;
    logic [7:0] frame_count;

    modport master (
        input  tick, enable, done_erase, done_update, done_draw,
        output start_erase, start_update, start_draw, busy, overrun, timeout, frame_count
    );

    modport slave (
        output tick, enable, done_erase, done_update, done_draw,
        input  start_erase, start_update, start_draw, busy, overrun, timeout, frame_count
    );
endinterface

// File: rtl/frame_scheduler.sv
// Frame scheduler: runs erase -> update -> draw once per accepted frame tick, with a
// per-phase watchdog and sticky overrun/timeout flags. All outputs are registered.
module frame_scheduler #(
    parameter int unsigned TIMEOUT = 800000,
    parameter int unsigned WD_W    = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    frame_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            phase_done, expired;

    logic       start_erase_q, start_update_q, start_draw_q;
    logic       start_erase_d, start_update_d, start_draw_d;
    logic       busy_q, overrun_q, timeout_q;
    logic       busy_d, overrun_d, timeout_d;
    logic [7:0] frame_count_q, frame_count_d;

    assign expired = (wd_q == WD_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wd_q           <= '0;
            start_erase_q  <= 1'b0;
            start_update_q <= 1'b0;
            start_draw_q   <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            start_erase_q  <= start_erase_d;
            start_update_q <= start_update_d;
            start_draw_q   <= start_draw_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
            frame_count_q  <= frame_count_d;
        end
    end

    // A start pulse is high only in the first cycle of its phase, so it also masks a
    // done level left over from before the engine was started.
    always_comb begin
        state_d    = state_q;
        phase_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tick && bus.enable) state_d = ERASE;
            end
            ERASE: begin
                phase_done = bus.done_erase && !start_erase_q;
                if (phase_done)   state_d = UPDATE;
                else if (expired) state_d = IDLE;
            end
            UPDATE: begin
                phase_done = bus.done_update && !start_update_q;
                if (phase_done)   state_d = DRAW;
                else if (expired) state_d = IDLE;
            end
            DRAW: begin
                phase_done = bus.done_draw && !start_draw_q;
                if (phase_done || expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_erase_d  = (state_q == IDLE)   && (state_d == ERASE);
        start_update_d = (state_q == ERASE)  && (state_d == UPDATE);
        start_draw_d   = (state_q == UPDATE) && (state_d == DRAW);
        busy_d         = (state_d != IDLE);
        overrun_d      = overrun_q || (bus.tick && (state_q != IDLE));
        // Any exit from a phase that was not its own done is a watchdog abort.
        timeout_d      = timeout_q || ((state_q != IDLE) && (state_d == IDLE) && !phase_done);
        frame_count_d  = frame_count_q + 8'((state_q == DRAW) && phase_done);
        wd_d           = ((state_q == IDLE) || (state_d != state_q)) ? '0 : wd_q + 1'b1;
    end

    assign bus.start_erase  = start_erase_q;
    assign bus.start_update = start_update_q;
    assign bus.start_draw   = start_draw_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;
    assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: a vector table of single-frame scenarios plus hand-written
// sequences for disabled ticks, frame counter wrap and reset during a draw.
module tb_frame_scheduler;
    localparam int TO  = 16;
    localparam int NEV = 99;

    logic clock = 1'b0;
    logic reset_n;

    frame_scheduler_if bus ();

    frame_scheduler #(.TIMEOUT(TO), .WD_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    typedef struct {
        logic       en;
        logic       tie;
        logic       drop;
        int         le, lu, ld, tick2;
        logic [7:0] x_fc;
        logic       x_ovr, x_to;
        int         x_su, x_sd;
    } vec_t;

    ev_t        fc_q[$];
    int         se_q[$];
    int         bf_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_se = 0, n_su = 0, n_sd = 0;
    int         ph = 0, age = 0;
    int         lat[3];
    logic       tied = 1'b0;
    logic       strict = 1'b0;
    logic [7:0] last_fc = 8'd0;
    logic [7:0] exp_fc = 8'd0;
    logic       last_busy = 1'b0;
    vec_t       vt[13];

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event at cycle %0d with nothing expected", name, cyc);
    endtask

    // One clock: observe outputs against the scoreboard, then drive the done levels.
    task automatic clk_step();
        ev_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (bus.start_erase === 1'b1) begin
            n_se++;
            if (se_q.size() > 0) chk("start_erase_cycle", cyc, se_q.pop_front());
            else if (strict) unexpected("start_erase_unexpected");
            ph = 1; age = 0;
        end else if (bus.start_update === 1'b1) begin
            n_su++; ph = 2; age = 0;
        end else if (bus.start_draw === 1'b1) begin
            n_sd++; ph = 3; age = 0;
        end else begin
            age++;
        end
        if (bus.busy !== 1'b1) ph = 0;
        if (bus.frame_count !== last_fc) begin
            if (fc_q.size() > 0) begin
                e = fc_q.pop_front();
                chk("frame_count_value", bus.frame_count, e.val);
                chk("frame_count_cycle", cyc, e.cyc);
            end else if (strict) unexpected("frame_count_change_unexpected");
            last_fc = bus.frame_count;
        end
        if (last_busy === 1'b1 && bus.busy === 1'b0) begin
            if (bf_q.size() > 0) chk("busy_fall_cycle", cyc, bf_q.pop_front());
            else if (strict) unexpected("busy_fall_unexpected");
        end
        last_busy = bus.busy;
        bus.done_erase  = tied || (ph == 1 && age >= lat[0]);
        bus.done_update = tied || (ph == 2 && age >= lat[1]);
        bus.done_draw   = tied || (ph == 3 && age >= lat[2]);
    endtask

    task automatic apply_reset();
        strict  = 1'b0;
        bus.tick = 1'b0;
        reset_n = 1'b0;
        clk_step();
        clk_step();
        reset_n = 1'b1;
        se_q.delete(); fc_q.delete(); bf_q.delete();
        n_se = 0; n_su = 0; n_sd = 0;
        exp_fc = 8'd0; last_fc = 8'd0; ph = 0;
        strict = 1'b1;
    endtask

    // Launch one frame tick from IDLE and push the expected start/finish events.
    task automatic run_frame(input logic en, tie, drop, input int le, lu, ld, tick2, run_len);
        int   s, eff, t0;
        logic aborted;
        lat[0] = le; lat[1] = lu; lat[2] = ld;
        tied = tie;
        bus.done_erase = tie; bus.done_update = tie; bus.done_draw = tie;
        bus.enable = en;
        bus.tick   = 1'b1;
        t0 = cyc;
        if (en) begin
            se_q.push_back(t0 + 1);
            s = t0 + 1;
            aborted = 1'b0;
            for (int k = 0; k < 3 && !aborted; k++) begin
                eff = (lat[k] == 0) ? 1 : lat[k];
                if (eff > TO - 1) begin
                    bf_q.push_back(s + TO);
                    aborted = 1'b1;
                end else begin
                    s = s + eff + 1;
                end
            end
            if (!aborted) begin
                exp_fc = exp_fc + 8'd1;
                fc_q.push_back('{s, exp_fc});
                bf_q.push_back(s);
            end
        end
        clk_step();
        bus.tick = 1'b0;
        if (drop) bus.enable = 1'b0;
        for (int i = 1; i < run_len; i++) begin
            if (tick2 != 0 && i == tick2) bus.tick = 1'b1;
            clk_step();
            bus.tick = 1'b0;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_start_erase"},  bus.start_erase,  0);
        chk({tag, "_start_update"}, bus.start_update, 0);
        chk({tag, "_start_draw"},   bus.start_draw,   0);
        chk({tag, "_busy"},         bus.busy,         0);
        chk({tag, "_overrun"},      bus.overrun,      0);
        chk({tag, "_timeout"},      bus.timeout,      0);
        chk({tag, "_frame_count"},  bus.frame_count,  0);
    endtask

    initial begin
        int se0, su0, sd0;
        //            en    tie   drop  le   lu   ld   t2  fc    ovr   to    su sd
        vt[0]  = '{1'b1, 1'b1, 1'b0, 0,   0,   0,   0,  8'd1, 1'b0, 1'b0, 1, 1};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1,   1,   1,   0,  8'd1, 1'b0, 1'b0, 1, 1};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 3,   2,   5,   0,  8'd1, 1'b0, 1'b0, 1, 1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 0,   0,   0,   0,  8'd1, 1'b0, 1'b0, 1, 1};
        vt[4]  = '{1'b1, 1'b0, 1'b0, NEV, 1,   1,   0,  8'd0, 1'b0, 1'b1, 0, 0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 2,   NEV, 1,   0,  8'd0, 1'b0, 1'b1, 1, 0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1,   1,   NEV, 0,  8'd0, 1'b0, 1'b1, 1, 1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 15,  1,   1,   0,  8'd1, 1'b0, 1'b0, 1, 1};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 16,  1,   1,   0,  8'd0, 1'b0, 1'b1, 0, 0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1,   1,   1,   3,  8'd1, 1'b1, 1'b0, 1, 1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1,   1,   1,   6,  8'd1, 1'b1, 1'b0, 1, 1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1,   1,   1,   4,  8'd0, 1'b0, 1'b0, 0, 0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1,   1,   15,  20, 8'd1, 1'b1, 1'b0, 1, 1};

        bus.tick = 1'b0; bus.enable = 1'b0;
        bus.done_erase = 1'b0; bus.done_update = 1'b0; bus.done_draw = 1'b0;
        lat[0] = NEV; lat[1] = NEV; lat[2] = NEV;

        apply_reset();
        chk_zero_outputs("reset");

        foreach (vt[i]) begin
            apply_reset();
            run_frame(vt[i].en, vt[i].tie, vt[i].drop, vt[i].le, vt[i].lu, vt[i].ld,
                      vt[i].tick2, 60);
            chk($sformatf("v%0d_se_pending", i), se_q.size(), 0);
            chk($sformatf("v%0d_fc_pending", i), fc_q.size(), 0);
            chk($sformatf("v%0d_bf_pending", i), bf_q.size(), 0);
            chk($sformatf("v%0d_busy", i),        bus.busy,        0);
            chk($sformatf("v%0d_overrun", i),     bus.overrun,     vt[i].x_ovr);
            chk($sformatf("v%0d_timeout", i),     bus.timeout,     vt[i].x_to);
            chk($sformatf("v%0d_frame_count", i), bus.frame_count, vt[i].x_fc);
            chk($sformatf("v%0d_n_start_erase", i),  n_se, vt[i].en ? 1 : 0);
            chk($sformatf("v%0d_n_start_update", i), n_su, vt[i].x_su);
            chk($sformatf("v%0d_n_start_draw", i),   n_sd, vt[i].x_sd);
        end

        // Ticks while disabled are ignored; the next enabled tick runs a normal frame.
        apply_reset();
        lat[0] = 1; lat[1] = 1; lat[2] = 1; tied = 1'b0;
        bus.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.tick = 1'b1;
            clk_step();
            bus.tick = 1'b0;
            clk_step();
            chk("dis_busy", bus.busy, 0);
        end
        chk("dis_n_start_erase", n_se, 0);
        chk("dis_overrun", bus.overrun, 0);
        chk("dis_timeout", bus.timeout, 0);
        run_frame(1'b1, 1'b0, 1'b0, 1, 1, 1, 0, 20);
        chk("dis_then_en_frame_count", bus.frame_count, 1);
        chk("dis_then_en_overrun", bus.overrun, 0);
        chk("dis_then_en_n_start_erase", n_se, 1);

        // 256 back-to-back frames with done tied high wrap the counter to zero.
        apply_reset();
        for (int f = 0; f < 256; f++) run_frame(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 8);
        chk("wrap_frame_count", bus.frame_count, exp_fc);
        chk("wrap_frame_count_zero", bus.frame_count, 0);
        chk("wrap_n_start_draw", n_sd, 256);
        chk("wrap_overrun", bus.overrun, 0);

        // Reset while stuck in DRAW, with a coincident tick.
        apply_reset();
        tied = 1'b0;
        lat[0] = 1; lat[1] = 1; lat[2] = NEV;
        bus.done_erase = 1'b0; bus.done_update = 1'b0; bus.done_draw = 1'b0;
        bus.enable = 1'b1;
        bus.tick = 1'b1;
        se_q.push_back(cyc + 1);
        clk_step();
        bus.tick = 1'b0;
        for (int k = 0; k < 20 && n_sd == 0; k++) clk_step();
        chk("rst_reached_draw", n_sd, 1);
        clk_step();
        clk_step();
        chk("rst_busy_in_draw", bus.busy, 1);
        strict = 1'b0;
        reset_n = 1'b0;
        bus.tick = 1'b1;
        clk_step();
        reset_n = 1'b1;
        bus.tick = 1'b0;
        chk_zero_outputs("rst_draw");
        se_q.delete(); fc_q.delete(); bf_q.delete();
        last_fc = 8'd0;
        strict = 1'b1;
        se0 = n_se; su0 = n_su; sd0 = n_sd;
        for (int k = 0; k < 10; k++) clk_step();
        chk("rst_after_n_start_erase", n_se - se0, 0);
        chk("rst_after_n_start_update", n_su - su0, 0);
        chk("rst_after_n_start_draw", n_sd - sd0, 0);
        chk("rst_after_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
